// File: rtl/nbit_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_regfile_pkg
//  Description : Shared types and helpers for the register file and the
//                memory-interface blocks: clear-sweep FSM state encoding and
//                the byte-lane merge used by byte-enabled writes.
//  Revision    : 1.0 - initial release
// ============================================================================
package nbit_regfile_pkg;

  localparam int c_BYTE_W = 8;

  // Clear-sweep controller states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  // Merge one byte lane: enabled lanes take new data, disabled lanes hold
  function automatic logic [c_BYTE_W-1:0] byte_merge(
    input logic [c_BYTE_W-1:0] data,
    input logic [c_BYTE_W-1:0] old,
    input logic                en
  );
    return en ? data : old;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nbit_reg_be.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_reg_be
//  Description : Single DATA_WIDTH register with per-byte write enables,
//                a synchronous zero input and async active-low reset.
//                Synchronous zero wins over a write in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module nbit_reg_be
  import nbit_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   q_o
);

  localparam int c_NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Next value: zero has priority, otherwise merge enabled bytes on write
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (we_i) begin
      for (int b = 0; b < c_NBYTES; b++) begin
        data_d[c_BYTE_W*b +: c_BYTE_W] =
          byte_merge(wdata_i[c_BYTE_W*b +: c_BYTE_W],
                     data_q[c_BYTE_W*b +: c_BYTE_W], be_i[b]);
      end
    end
  end

  // Storage with asynchronous active-low reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/nbit_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_regfile
//  Description : 2R/1W register file with byte enables, optional hardwired
//                zero register, optional write-to-read bypass and a
//                DEPTH-cycle clear sweep driven by a small FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module nbit_regfile
  import nbit_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [ADDR_WIDTH-1:0]   RdAddrA,
  output logic [DATA_WIDTH-1:0]   RdDataA,
  input  logic [ADDR_WIDTH-1:0]   RdAddrB,
  output logic [DATA_WIDTH-1:0]   RdDataB,
  input  logic                    Write,
  input  logic [ADDR_WIDTH-1:0]   WrAddr,
  input  logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH/8-1:0] WrByteEn,
  input  logic                    Clear,
  output logic                    Busy
);

  localparam int                    c_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int                    c_NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_LAST   = {ADDR_WIDTH{1'b1}};

  rf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] w_entry [c_DEPTH];
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic                  w_wr_accept;
  logic                  w_wr_zero;
  logic                  w_sweep;

  // A write to entry 0 is dropped outright when it is hardwired to zero
  assign w_wr_zero   = (ZERO_REG != 0) && (WrAddr == '0);
  // Clear wins over Write in IDLE; both are ignored during the sweep
  assign w_wr_accept = Write && (state_q == ST_IDLE) && !Clear && !w_wr_zero;
  assign w_sweep     = (state_q == ST_CLEAR);

  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_entry
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign w_entry[gi] = '0;
    end else begin : g_reg
      nbit_reg_be #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_reg (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr_i   (w_sweep && (cnt_q == ADDR_WIDTH'(gi))),
        .we_i    (w_wr_accept && (WrAddr == ADDR_WIDTH'(gi))),
        .be_i    (WrByteEn),
        .wdata_i (WrData),
        .q_o     (w_entry[gi])
      );
    end
  end

  // Value the write target will hold after the next edge, for bypass
  always_comb begin
    w_wr_merged = '0;
    for (int b = 0; b < c_NBYTES; b++) begin
      w_wr_merged[c_BYTE_W*b +: c_BYTE_W] =
        byte_merge(WrData[c_BYTE_W*b +: c_BYTE_W],
                   w_entry[WrAddr][c_BYTE_W*b +: c_BYTE_W], WrByteEn[b]);
    end
  end

  // Read port A: stored value, optional forwarding, zero register last
  always_comb begin
    RdDataA = w_entry[RdAddrA];
    if ((BYPASS != 0) && w_wr_accept && (RdAddrA == WrAddr)) begin
      RdDataA = w_wr_merged;
    end
    if ((ZERO_REG != 0) && (RdAddrA == '0)) begin
      RdDataA = '0;
    end
  end

  // Read port B: same structure as port A
  always_comb begin
    RdDataB = w_entry[RdAddrB];
    if ((BYPASS != 0) && w_wr_accept && (RdAddrB == WrAddr)) begin
      RdDataB = w_wr_merged;
    end
    if ((ZERO_REG != 0) && (RdAddrB == '0)) begin
      RdDataB = '0;
    end
  end

  // Clear-sweep FSM; terminal compare at the last index stops the counter
  // wrap from starting a second pass
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Clear) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nbit_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nbit_regfile
//  Description : Scoreboard bench for nbit_regfile. Two instances share all
//                inputs: one with BYPASS=1, one with BYPASS=0. Stimulus
//                pushes hand-computed expectations; a monitor pops and
//                compares them at the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_regfile;

  logic        Clk;
  logic        Reset;
  logic [4:0]  RdAddrA, RdAddrB, WrAddr;
  logic [31:0] RdDataA, RdDataB, RdDataA_nb, RdDataB_nb;
  logic        Write, Clear, Busy, Busy_nb;
  logic [31:0] WrData;
  logic [3:0]  WrByteEn;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] a_nb;
    logic [31:0] b_nb;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  event chk_ev;

  nbit_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .RdAddrA(RdAddrA), .RdDataA(RdDataA),
    .RdAddrB(RdAddrB), .RdDataB(RdDataB),
    .Write(Write), .WrAddr(WrAddr), .WrData(WrData), .WrByteEn(WrByteEn),
    .Clear(Clear), .Busy(Busy)
  );

  nbit_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .Clk(Clk), .Reset(Reset),
    .RdAddrA(RdAddrA), .RdDataA(RdDataA_nb),
    .RdAddrB(RdAddrB), .RdDataB(RdDataB_nb),
    .Write(Write), .WrAddr(WrAddr), .WrData(WrData), .WrByteEn(WrByteEn),
    .Clear(Clear), .Busy(Busy_nb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endfunction

  // Monitor: drain all pending expectations at each falling edge or on demand
  always begin
    @(negedge Clk or chk_ev);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp({e.name, ".A"},       RdDataA,          e.a);
      cmp({e.name, ".B"},       RdDataB,          e.b);
      cmp({e.name, ".A_nb"},    RdDataA_nb,       e.a_nb);
      cmp({e.name, ".B_nb"},    RdDataB_nb,       e.b_nb);
      cmp({e.name, ".Busy"},    {31'd0, Busy},    {31'd0, e.busy});
      cmp({e.name, ".Busy_nb"}, {31'd0, Busy_nb}, {31'd0, e.busy});
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] a_nb, input logic [31:0] b_nb, input logic busy);
    exp_t e;
    e.name = nm; e.a = a; e.b = b; e.a_nb = a_nb; e.b_nb = b_nb; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_wr(input logic w, input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    Write = w; WrAddr = addr; WrData = data; WrByteEn = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; Clear = 1'b0;
    drive_wr(1'b0, 5'd0, 32'd0, 4'h0);
    RdAddrA = 5'd3; RdAddrB = 5'd31;
    #1;
    push_exp("rst_hold", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(); step();
    Reset = 1'b1;
    push_exp("rst_rel", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Full write with same-cycle forwarding, then partial byte write
    step();
    drive_wr(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    RdAddrA = 5'd5;
    push_exp("wr5_full_bp", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    drive_wr(1'b1, 5'd5, 32'h00B0B000, 4'b0110);
    push_exp("wr5_be_bp", 32'hDEB0B0EF, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
    step();
    drive_wr(1'b0, 5'd0, 32'd0, 4'h0);
    push_exp("wr5_be", 32'hDEB0B0EF, 32'h0, 32'hDEB0B0EF, 32'h0, 1'b0);

    // Zero register ignores writes and never forwards
    step();
    drive_wr(1'b1, 5'd0, 32'hBADF000D, 4'hF);
    RdAddrB = 5'd0;
    push_exp("zr_bp", 32'hDEB0B0EF, 32'h0, 32'hDEB0B0EF, 32'h0, 1'b0);
    step();
    drive_wr(1'b0, 5'd0, 32'd0, 4'h0);
    RdAddrA = 5'd0;
    push_exp("zr_rd", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Forwarding of a partial write versus non-forwarding instance
    step();
    drive_wr(1'b1, 5'd7, 32'h11111111, 4'hF);
    RdAddrA = 5'd7; RdAddrB = 5'd5;
    push_exp("wr7_full_bp", 32'h11111111, 32'hDEB0B0EF, 32'h0, 32'hDEB0B0EF, 1'b0);
    step();
    drive_wr(1'b1, 5'd7, 32'h22222222, 4'b0011);
    push_exp("wr7_be_bp", 32'h11112222, 32'hDEB0B0EF, 32'h11111111, 32'hDEB0B0EF, 1'b0);
    step();
    drive_wr(1'b1, 5'd7, 32'h33333333, 4'h0);
    push_exp("wr7_be0_bp", 32'h11112222, 32'hDEB0B0EF, 32'h11112222, 32'hDEB0B0EF, 1'b0);
    step();
    drive_wr(1'b0, 5'd0, 32'd0, 4'h0);
    push_exp("wr7_be0", 32'h11112222, 32'hDEB0B0EF, 32'h11112222, 32'hDEB0B0EF, 1'b0);

    // Fill, then clear sweep with a colliding write and repeated Clear
    for (int i = 1; i < 32; i++) begin
      step();
      drive_wr(1'b1, 5'(i), 32'h1000_0000 | i, 4'hF);
    end
    step();
    drive_wr(1'b1, 5'd9, 32'hFFFFFFFF, 4'hF);
    Clear = 1'b1;
    RdAddrA = 5'd9; RdAddrB = 5'd31;
    push_exp("clr_req", 32'h10000009, 32'h1000001F, 32'h10000009, 32'h1000001F, 1'b0);
    step();
    push_exp("clr_p0", 32'h10000009, 32'h1000001F, 32'h10000009, 32'h1000001F, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      logic [31:0] ea;
      step();
      if (k == 31) begin
        drive_wr(1'b0, 5'd0, 32'd0, 4'h0);
        Clear = 1'b0;
      end
      RdAddrB = 5'(k - 1);
      ea = (k >= 10) ? 32'h0 : 32'h10000009;
      push_exp($sformatf("sweep_k%0d", k), ea, 32'h0, ea, 32'h0, (k < 32));
    end
    for (int j = 0; j < 16; j++) begin
      step();
      RdAddrA = 5'(2 * j); RdAddrB = 5'(2 * j + 1);
      push_exp($sformatf("post_clr_%0d", j), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    end

    // Reset in the middle of a sweep
    for (int i = 1; i < 32; i++) begin
      step();
      drive_wr(1'b1, 5'(i), 32'h2000_0000 | i, 4'hF);
    end
    step();
    drive_wr(1'b0, 5'd0, 32'd0, 4'h0);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    RdAddrA = 5'd20; RdAddrB = 5'd31;
    for (int k = 1; k <= 10; k++) step();
    push_exp("pre_abort", 32'h20000014, 32'h2000001F, 32'h20000014, 32'h2000001F, 1'b1);
    @(negedge Clk);
    #1 Reset = 1'b0;
    #1;
    push_exp("abort", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    -> chk_ev;
    step(); step();
    Reset = 1'b1;
    drive_wr(1'b1, 5'd20, 32'hCAFEF00D, 4'hF);
    push_exp("wr20_bp", 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    drive_wr(1'b0, 5'd0, 32'd0, 4'h0);
    push_exp("wr20", 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    step(); step(); step();
    push_exp("no_resume", 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);

    step(); step();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: actual %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nbit_regfile.md
Name: nbit_regfile

Overview:
Parametrised multi-entry successor to the single n-bit register, used as the architectural register file of the multicycle datapath. It has two asynchronous read ports and one synchronous write port with byte enables. Register 0 can optionally be hardwired to zero, and write-to-read bypass is optional. A multi-cycle clear sweep is controlled by a small state machine, so software/control can zero the file without a reset.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries (derived, not overridable).
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle accepted write is forwarded to matching read ports.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- RdAddrA  in  ADDR_WIDTH  read port A address.
- RdDataA  out  DATA_WIDTH  read port A data (combinational).
- RdAddrB  in  ADDR_WIDTH  read port B address.
- RdDataB  out  DATA_WIDTH  read port B data (combinational).
- Write  in  1  write request, sampled on rising Clk.
- WrAddr  in  ADDR_WIDTH  write address.
- WrData  in  DATA_WIDTH  write data.
- WrByteEn  in  DATA_WIDTH/8  byte enables; bit i controls WrData[8i+7:8i].
- Clear  in  1  starts clear sweep, sampled on rising Clk.
- Busy  out  1  high while clear sweep is in progress.

Behaviour:
- Reset=0, asynchronous: all entries 0, state IDLE, sweep counter 0, Busy=0. Hence RdDataA/B=0 during and after reset.
- Reads: RdDataX = entry[RdAddrX], combinational, zero latency.
- Read of addr 0 with ZERO_REG=1 returns 0 regardless of stored value or bypass.
- Write is accepted when Write=1, state IDLE and Clear=0 at the rising edge.
- Accepted write updates only enabled bytes of entry[WrAddr]; disabled bytes hold. Write latency is 1 edge.
- WrByteEn=0 is a legal no-op.
- WrAddr=0 with ZERO_REG=1: write discarded.
- Bypass (BYPASS=1): while a write would be accepted at the next edge and RdAddrX==WrAddr (and not the zero register), RdDataX = byte-merge(WrData, entry, WrByteEn). This is combinational.
- Bypass (BYPASS=0): reads return the old value until the edge.
- Both read ports may address the same or any entries simultaneously.
- FSM IDLE: Clear=1 at edge -> CLEAR, counter<=0, Busy<=1. A Write in that same cycle is dropped (Clear has priority).
- FSM CLEAR: each edge zeroes entry[counter] and increments counter. When counter==DEPTH-1, that entry is zeroed, state -> IDLE and Busy<=0.
- Sweep takes exactly DEPTH cycles; Busy is high for DEPTH cycles.
- During CLEAR: Write ignored (no bypass), Clear ignored (no restart). Reads return current contents, which may be a mix of cleared and uncleared entries.
- Counter wrap: the counter is ADDR_WIDTH bits; the terminal compare at DEPTH-1 prevents a second pass.
- Reset=0 mid-sweep aborts immediately to the reset state; the sweep does not resume.
- Write to an address the sweep has already passed is impossible (write ignored while Busy).

Decomposition:
- Shared package: FSM state encoding (IDLE, CLEAR) and a byte-merge function (data, old, byte-enable -> merged). Both are reused by the memory-interface blocks.
- One natural sub-module: nbit_reg_be, a single DATA_WIDTH register with byte enables, synchronous zero, and async active-low Reset. It is instantiated DEPTH times by generate.
- Read mux, bypass and FSM stay in the top level.

Test Plan:
- Reset low then high; read A=3, B=31 -> both 0, Busy=0.
- Write addr 5 = 0xDEADBEEF, WrByteEn=4'hF; next cycle read A=5 -> 0xDEADBEEF. Then write 0x00B0B000 with WrByteEn=4'b0110 -> 0xDEB0B0EF.
- ZERO_REG=1: write addr 0 = 0xBADF000D; read A=0 -> 0. With BYPASS=1, same-cycle read B=0 -> 0.
- BYPASS=1: entry 7=0x11111111; assert Write addr 7 = 0x22222222, WrByteEn=4'b0011; same cycle read A=7 -> 0x11112222. With BYPASS=0 -> 0x11111111 until the edge.
- Fill all entries with nonzero data; pulse Clear with Write to addr 9 in the same cycle. Expect Busy high exactly 32 cycles, writes and a second Clear ignored, entry 9 never updated, all reads 0 afterward.
- Start a sweep, drop Reset at counter=10 -> all entries 0 and Busy=0 immediately; after release, a write to addr 20 is accepted on the first edge.
